// File: rtl/delay_slot_sched_if.sv
// Requester-side bundle for the shared delay timer: requests in, grant/done/status out.
interface delay_slot_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 16
) ();
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_delay;
    logic [NREQ-1:0]    req_unit;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [IW-1:0]      cur_id;

    modport master (
        output req, req_delay, req_unit,
        input  gnt, done, busy, cur_id
    );

    modport slave (
        input  req, req_delay, req_unit,
        output gnt, done, busy, cur_id
    );
endinterface

// File: rtl/delay_slot_sched.sv
// Shared delay-timer scheduler: round-robin arbitration over NREQ requesters, one delay
// at a time measured in precision ticks or whole time units, sticky global finish.
module delay_slot_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 16,
    parameter int unsigned PW   = 8,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [PW-1:0]         cfg_prescale,
    input  logic [PW-1:0]         cfg_ratio,
    input  logic                  finish_req,
    output logic                  finished,
    delay_slot_sched_if.slave     bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e          state_q;
    logic [IW-1:0]   ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;
    logic [IW-1:0]   cur_id_q;
    logic            finished_q;

    // Latched job parameters and the three nested counters
    logic [DW-1:0]   dly_q;
    logic [PW-1:0]   pre_q;
    logic [PW-1:0]   pre_max_q;
    logic [PW-1:0]   rat_q;
    logic [PW-1:0]   rat_max_q;

    logic            any_req;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   ptr_next;
    logic [DW-1:0]   win_delay;
    logic [PW-1:0]   ratio_last;
    logic            pre_wrap;
    logic            rat_wrap;
    logic            expire;
    logic [IW:0]     cand_sum;

    // Round-robin search starting at ptr_q, plus the job parameters of the winner
    always_comb begin
        any_req  = 1'b0;
        winner   = '0;
        cand_sum = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IW+1)'(NREQ);
            end
            if (!any_req && bus.req[cand_sum[IW-1:0]]) begin
                any_req = 1'b1;
                winner  = cand_sum[IW-1:0];
            end
        end
        ptr_next   = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
        win_delay  = bus.req_delay[winner*DW +: DW];
        // Ratio 0 behaves as 1, i.e. the ratio counter never advances
        ratio_last = (cfg_ratio == '0) ? '0 : cfg_ratio - 1'b1;
    end

    // Expiry is detected on the last counted cycle so done registers one cycle later
    always_comb begin
        pre_wrap = (pre_q == pre_max_q);
        rat_wrap = (rat_q == rat_max_q);
        expire   = (dly_q == '0) || ((dly_q == DW'(1)) && pre_wrap && rat_wrap);
    end

    // Scheduler FSM with registered outputs; finish_req overrides every other action
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            cur_id_q   <= '0;
            finished_q <= 1'b0;
            dly_q      <= '0;
            pre_q      <= '0;
            pre_max_q  <= '0;
            rat_q      <= '0;
            rat_max_q  <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            if (finish_req) begin
                state_q    <= StFin;
                finished_q <= 1'b1;
                busy_q     <= 1'b0;
                cur_id_q   <= '0;
                dly_q      <= '0;
                pre_q      <= '0;
                rat_q      <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (any_req) begin
                            state_q   <= StRun;
                            gnt_q     <= NREQ'(1) << winner;
                            busy_q    <= 1'b1;
                            cur_id_q  <= winner;
                            ptr_q     <= ptr_next;
                            dly_q     <= win_delay;
                            pre_max_q <= cfg_prescale;
                            rat_max_q <= bus.req_unit[winner] ? ratio_last : '0;
                            pre_q     <= '0;
                            rat_q     <= '0;
                        end else begin
                            busy_q   <= 1'b0;
                            cur_id_q <= '0;
                        end
                    end
                    StRun: begin
                        if (expire) begin
                            // busy/cur_id stay up through the done cycle
                            state_q <= StIdle;
                            done_q  <= NREQ'(1) << cur_id_q;
                        end else if (pre_wrap) begin
                            pre_q <= '0;
                            if (rat_wrap) begin
                                rat_q <= '0;
                                dly_q <= dly_q - 1'b1;
                            end else begin
                                rat_q <= rat_q + 1'b1;
                            end
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end
                    StFin: begin
                        state_q <= StFin;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.cur_id = cur_id_q;
    assign finished   = finished_q;

endmodule

// File: tb/tb_delay_slot_sched.sv
// Directed bench for delay_slot_sched with hand-computed grant/done timing.
module tb_delay_slot_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned PW   = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [PW-1:0] cfg_prescale = '0;
    logic [PW-1:0] cfg_ratio = 8'd1;
    logic          finish_req = 1'b0;
    logic          finished;

    int n_checks = 0;
    int n_errors = 0;

    delay_slot_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

    delay_slot_sched #(.NREQ(NREQ), .DW(DW), .PW(PW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cfg_prescale (cfg_prescale),
        .cfg_ratio    (cfg_ratio),
        .finish_req   (finish_req),
        .finished     (finished),
        .bus          (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; leaves us 1ns after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int lane, input int d, input logic unit);
        bus.req_delay[lane*DW +: DW] = DW'(d);
        bus.req_unit[lane] = unit;
    endtask

    // Count cycles from the grant cycle until done, bounded
    task automatic run_to_done(input string tag, input int lane, input int exp_lat,
                               input int bound);
        int lat;
        lat = 0;
        while (bus.done == '0 && lat < bound) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_lane"}, 32'(bus.done), 32'(1 << lane));
        check({tag, "_busy"}, 32'(bus.busy), 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        int order[5];
        logic [NREQ-1:0] seen;

        bus.req = '0;
        bus.req_delay = '0;
        bus.req_unit = '0;

        // Reset values
        do_reset();
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cur_id", 32'(bus.cur_id), 0);
        check("rst_finished", 32'(finished), 0);

        // Lane 0, D=3 ticks, P=0: gnt at t+1, done at g+3
        cfg_prescale = 8'd0;
        cfg_ratio = 8'd1;
        set_lane(0, 3, 1'b0);
        bus.req[0] = 1'b1;
        step();
        check("t1_gnt", 32'(bus.gnt), 32'h1);
        check("t1_busy_g", 32'(bus.busy), 1);
        bus.req[0] = 1'b0;
        step();
        check("t1_done_early", 32'(bus.done), 0);
        check("t1_busy_mid", 32'(bus.busy), 1);
        step();
        step();
        check("t1_done", 32'(bus.done), 32'h1);
        check("t1_busy_d", 32'(bus.busy), 1);
        step();
        check("t1_done_after", 32'(bus.done), 0);
        check("t1_busy_after", 32'(bus.busy), 0);

        // Lane 2, D=2 units, P=1, M=10: 40 cycles; ratio change at g+5 is ignored
        cfg_prescale = 8'd1;
        cfg_ratio = 8'd10;
        set_lane(2, 2, 1'b1);
        bus.req[2] = 1'b1;
        step();
        check("t2_gnt", 32'(bus.gnt), 32'h4);
        check("t2_cur_id", 32'(bus.cur_id), 2);
        bus.req[2] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        cfg_ratio = 8'd3;
        run_to_done("t2", 2, 35, 60);
        step();

        // All four lanes, D=1, P=0: order 0,1,2,3 then lane 0 again
        do_reset();
        cfg_prescale = 8'd0;
        cfg_ratio = 8'd1;
        for (int l = 0; l < 4; l++) set_lane(l, 1, 1'b0);
        bus.req = 4'hf;
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t3_gnt%0d", i), 32'(bus.gnt), 32'(1 << order[i]));
            bus.req[order[i]] = 1'b0;
            step();
            check($sformatf("t3_done%0d", i), 32'(bus.done), 32'(1 << order[i]));
            check($sformatf("t3_nognt%0d", i), 32'(bus.gnt), 0);
            if (i == 0) bus.req[0] = 1'b1;
        end
        step();

        // D=0 on lane 1 with maximal P and M: done one cycle after grant
        cfg_prescale = 8'd255;
        cfg_ratio = 8'd255;
        set_lane(1, 0, 1'b1);
        bus.req[1] = 1'b1;
        step();
        check("t4_gnt", 32'(bus.gnt), 32'h2);
        bus.req[1] = 1'b0;
        step();
        check("t4_done", 32'(bus.done), 32'h2);
        step();
        check("t4_idle", 32'(bus.busy), 0);

        // finish_req mid-run on lane 3
        cfg_prescale = 8'd0;
        cfg_ratio = 8'd1;
        set_lane(3, 100, 1'b0);
        bus.req[3] = 1'b1;
        step();
        check("t5_gnt", 32'(bus.gnt), 32'h8);
        check("t5_cur_id", 32'(bus.cur_id), 3);
        bus.req[3] = 1'b0;
        for (int i = 0; i < 20; i++) step();
        finish_req = 1'b1;
        step();
        finish_req = 1'b0;
        check("t5_finished", 32'(finished), 1);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_cur_id_fin", 32'(bus.cur_id), 0);
        bus.req = 4'hf;
        seen = '0;
        for (int i = 0; i < 150; i++) begin
            step();
            seen = seen | bus.gnt | bus.done;
        end
        check("t5_silent", 32'(seen), 0);
        check("t5_sticky", 32'(finished), 1);
        bus.req = '0;

        // Reset mid-run: outputs clear immediately, then a fresh full-length grant
        do_reset();
        check("t6_fin_clr", 32'(finished), 0);
        set_lane(3, 50, 1'b0);
        bus.req[3] = 1'b1;
        step();
        check("t6_gnt3", 32'(bus.gnt), 32'h8);
        bus.req[3] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset_n = 1'b0;
        #2;
        check("t6_busy_async", 32'(bus.busy), 0);
        check("t6_cur_id_async", 32'(bus.cur_id), 0);
        step();
        reset_n = 1'b1;
        set_lane(2, 5, 1'b0);
        bus.req[2] = 1'b1;
        step();
        check("t6_gnt2", 32'(bus.gnt), 32'h4);
        check("t6_cur_id", 32'(bus.cur_id), 2);
        bus.req[2] = 1'b0;
        run_to_done("t6", 2, 5, 20);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/delay_slot_sched.md
# delay_slot_sched

Shared delay-timer scheduler for the timescale diagnostic designs. Several requesters (one per module instance, each possibly running at a different time unit) share a single prescaled delay timer. The block arbitrates round-robin, runs one delay at a time in precision ticks or whole time units, and pulses completion back to the winner. A global finish request stops all scheduling permanently.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 16, delay field width per requester
- PW, 8, prescale and ratio field width
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cfg_prescale  in  PW  clocks per precision tick minus 1 (P; tick = P+1 clocks)
- cfg_ratio  in  PW  precision ticks per time unit (M); 0 treated as 1
- req  in  NREQ  level request per requester; held until gnt
- req_delay  in  NREQ*DW  delay count D, lane i at [i*DW +: DW]
- req_unit  in  NREQ  per lane: 1 = D in time units, 0 = D in precision ticks
- finish_req  in  1  abort and stop scheduler, sticky effect
- gnt  out  NREQ  one-hot, one-cycle pulse when lane's delay is accepted
- done  out  NREQ  one-hot, one-cycle pulse when lane's delay expires
- busy  out  1  high while a delay is running (from gnt cycle through done cycle)
- cur_id  out  clog2(NREQ)  lane currently owning the timer; 0 when idle
- finished  out  1  sticky, set by finish_req

## Operation
- States: IDLE, RUN, FIN.
- IDLE: if any req and not finish_req, pick winner by round-robin starting at pointer ptr; next cycle: gnt[winner]=1, state RUN, D/unit/P/M latched from that lane and cfg inputs.
- ptr resets to 0; after grant to lane i, ptr = (i+1) mod NREQ.
- RUN: nested counters: prescale counter (0..P), ratio counter (0..M-1, used only if unit=1), delay counter (D down to 0). No single wide product counter; no overflow for any input values.
- Expiry: done[cur_id] pulses; busy still high that cycle; state returns to IDLE on the following cycle. Arbitration is evaluated in the done cycle, so back-to-back grant lands the cycle after done.
- cfg_prescale/cfg_ratio/req_delay changes after the grant have no effect on the running delay.
- req dropped before gnt withdraws the request; req held while owning the timer is ignored until done, then re-arbitrated normally (pointer already advanced).
- finish_req (any state, sampled each cycle): next cycle state FIN, finished=1, running delay abandoned with no done pulse, busy=0, gnt/done never assert again until reset. finish_req wins over a same-cycle grant or expiry.
- Reset (async, any time): state IDLE, ptr=0, all counters 0.

## Timing
- Reset values: gnt=0, done=0, busy=0, cur_id=0, finished=0.
- Grant latency: req high at cycle t in IDLE -> gnt at t+1.
- Expiry: gnt at cycle g -> done at g + max(1, D*(P+1)*Meff), Meff = M if unit=1 else 1 (M=0 counts as 1).
- D=0: done at g+1 regardless of P/M.
- Max throughput: one delay per (duration + 1) cycles.
- gnt and done never both high for the same lane in the same cycle; gnt may coincide with nothing else.

## Test plan
- Single lane 0, D=3, unit=0, P=0: req at cycle 1 -> gnt[0] at 2, done[0] at 5, busy high cycles 2..5.
- Lane 2, D=2, unit=1, P=1, M=10: gnt at g -> done[2] at g+40; changing cfg_ratio to 3 at g+5 does not shorten it.
- All four lanes request with D=1, P=0: grants in order 0,1,2,3 each one cycle after prior done; lane 0 re-requesting after its done waits behind 1,2,3.
- D=0 on lane 1, P=255, M=255 unit=1: done[1] exactly one cycle after gnt[1].
- finish_req mid-run (lane 3, D=100, after 20 cycles): no done[3], finished=1 and busy=0 next cycle, later req gets no gnt.
- reset_n low mid-run: all outputs 0 immediately; after release, req on lane 2 granted first (ptr=0, lane 2 only requester) with full fresh duration.
